l2_responder: RTL and testbench

Next-level (L2) side of the L1 data-cache miss interface. Accepts line-granular requests from the L1 (26-bit line address plus bus operation) through a small request FIFO, services them one at a time after a fixed access latency, and returns a completion handshake. It also keeps per-operation request counters, so L1/L2 traffic can be checked against the L1 hit/miss/read statistics.

---
 rtl/l2_pkg.sv | 35 +++
 rtl/l2_req_fifo.sv | 54 +++++
 rtl/l2_responder.sv | 132 +++++++++++++
 tb/tb_l2_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_pkg.sv
// Shared definitions for the L2 responder: bus op encodings, FSM states,
// the default line-address width and the saturating counter step.
package l2_pkg;

    // Line-address width shared with the L1 data cache add_out port.
    localparam int L2_ADDRBITS = 26;

    typedef enum logic [1:0] {
        OP_READ   = 2'd0,
        OP_WRITE  = 2'd1,
        OP_RFO    = 2'd2,
        OP_RETURN = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // Next value of a request counter: clear wins but still counts a
    // coincident hit; otherwise increment and stick at all-ones.
    function automatic logic [31:0] cnt_next(input logic [31:0] cur,
                                             input logic        clr,
                                             input logic        hit);
        logic [31:0] nxt;
        nxt = cur;
        if (clr)
            nxt = hit ? 32'd1 : 32'd0;
        else if (hit && (cur != 32'hFFFF_FFFF))
            nxt = cur + 32'd1;
        return nxt;
    endfunction

endpackage

// File: rtl/l2_req_fifo.sv
// Request FIFO: power-of-two depth, pointers carry an extra wrap bit so
// full and empty are told apart without a separate count.
module l2_req_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                   (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign dout  = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer update; reset empties the queue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every
        // register samples pre-edge values regardless of block order.
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    // Storage write.
    // NOTE: the data array is not reset; the pointers alone define which
    // entries are valid, so clearing storage would only cost logic.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/l2_responder.sv
// L2 side of the L1 miss interface: queues line requests, serves one at a
// time after a fixed latency, returns a completion handshake and counts
// accepted requests per bus operation.
module l2_responder
    import l2_pkg::*;
#(
    parameter int ADDRBITS = L2_ADDRBITS,
    parameter int LATENCY  = 4,
    parameter int DEPTH    = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                req_valid,
    input  logic [1:0]          req_op,
    input  logic [ADDRBITS-1:0] req_addr,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [1:0]          rsp_op,
    output logic [ADDRBITS-1:0] rsp_addr,
    input  logic                rsp_ready,
    output logic                busy,
    output logic [31:0]         cnt_read,
    output logic [31:0]         cnt_write,
    output logic [31:0]         cnt_rfo,
    output logic [31:0]         cnt_return
);

    localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

    state_e                r_state;
    state_e                w_state_nxt;
    logic [7:0]            r_wait;
    op_e                   r_op;
    logic [ADDRBITS-1:0]   r_addr;
    logic [31:0]           r_cnt_read;
    logic [31:0]           r_cnt_write;
    logic [31:0]           r_cnt_rfo;
    logic [31:0]           r_cnt_return;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_full;
    logic                  w_empty;
    logic [ADDRBITS+1:0]   w_dout;

    assign req_ready = !w_full && !rst;
    assign w_push    = req_valid && req_ready;

    l2_req_fifo #(
        .WIDTH (ADDRBITS + 2),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   ({req_op, req_addr}),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    // FSM next state and FIFO pop decision.
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned,
        // which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (r_wait == 8'd0) w_state_nxt = RESP;
            end
            RESP: begin
                if (rsp_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Captured request and service countdown.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait <= 8'd0;
            r_op   <= OP_READ;
            r_addr <= '0;
        end else if (w_pop) begin
            r_wait <= WAIT_LOAD;
            r_op   <= op_e'(w_dout[ADDRBITS+1:ADDRBITS]);
            r_addr <= w_dout[ADDRBITS-1:0];
        end else if ((r_state == WAIT) && (r_wait != 8'd0)) begin
            r_wait <= r_wait - 8'd1;
        end
    end

    // Per-op accepted-request counters, updated every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_read   <= 32'd0;
            r_cnt_write  <= 32'd0;
            r_cnt_rfo    <= 32'd0;
            r_cnt_return <= 32'd0;
        end else begin
            r_cnt_read   <= cnt_next(r_cnt_read,   clear, w_push && (req_op == OP_READ));
            r_cnt_write  <= cnt_next(r_cnt_write,  clear, w_push && (req_op == OP_WRITE));
            r_cnt_rfo    <= cnt_next(r_cnt_rfo,    clear, w_push && (req_op == OP_RFO));
            r_cnt_return <= cnt_next(r_cnt_return, clear, w_push && (req_op == OP_RETURN));
        end
    end

    assign rsp_valid  = (r_state == RESP);
    assign rsp_op     = r_op;
    assign rsp_addr   = r_addr;
    assign busy       = (r_state != IDLE) || !w_empty;
    assign cnt_read   = r_cnt_read;
    assign cnt_write  = r_cnt_write;
    assign cnt_rfo    = r_cnt_rfo;
    assign cnt_return = r_cnt_return;

endmodule

// File: tb/tb_l2_responder.sv
// Directed bench for l2_responder (ADDRBITS=26, LATENCY=4, DEPTH=4).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_l2_responder;
    import l2_pkg::*;

    localparam int AB = 26;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          req_valid;
    logic [1:0]    req_op;
    logic [AB-1:0] req_addr;
    logic          req_ready;
    logic          rsp_valid;
    logic [1:0]    rsp_op;
    logic [AB-1:0] rsp_addr;
    logic          rsp_ready;
    logic          busy;
    logic [31:0]   cnt_read;
    logic [31:0]   cnt_write;
    logic [31:0]   cnt_rfo;
    logic [31:0]   cnt_return;

    int total = 0;
    int bad   = 0;

    l2_responder #(.ADDRBITS(AB), .LATENCY(4), .DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .clear      (clear),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_op     (rsp_op),
        .rsp_addr   (rsp_addr),
        .rsp_ready  (rsp_ready),
        .busy       (busy),
        .cnt_read   (cnt_read),
        .cnt_write  (cnt_write),
        .cnt_rfo    (cnt_rfo),
        .cnt_return (cnt_return)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a response, compare it, then pass the handshake edge.
    task automatic expect_rsp(input string tag, input logic [1:0] op, input logic [AB-1:0] addr);
        int n = 0;
        while (!rsp_valid && n < 30) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_op"},    32'(rsp_op),    32'(op));
        check({tag, "_addr"},  32'(rsp_addr),  32'(addr));
        tick();
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check({tag, "_drained"}, 32'(busy), 32'd0);
    endtask

    logic [1:0]    v_op   [6];
    logic [AB-1:0] v_addr [6];
    bit            stable;
    bit            saw_rsp;

    initial begin
        v_op   = '{OP_READ, OP_WRITE, OP_RFO, OP_RETURN, OP_READ, OP_WRITE};
        v_addr = '{26'h0100001, 26'h0200002, 26'h0300003,
                   26'h3FFFFFF, 26'h0000000, 26'h1555555};

        rst = 1'b1; clear = 1'b0; req_valid = 1'b0; req_op = 2'd0;
        req_addr = '0; rsp_ready = 1'b0;
        tick();
        tick();

        // Reset values
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_addr",  32'(rsp_addr),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_cnt_read",  cnt_read,       32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'd1);

        // Single READ: accept at edge 1, response from edge 6
        rsp_ready = 1'b1;
        req_valid = 1'b1; req_op = OP_READ; req_addr = 26'h0ABCDE;
        tick();                                   // edge 1
        req_valid = 1'b0;
        check("t1_cnt_read", cnt_read, 32'd1);
        tick(); tick(); tick(); tick();           // edges 2..5
        check("t1_not_early", 32'(rsp_valid), 32'd0);
        tick();                                   // edge 6
        check("t1_valid", 32'(rsp_valid), 32'd1);
        check("t1_op",    32'(rsp_op),    32'd0);
        check("t1_addr",  32'(rsp_addr),  32'h0ABCDE);
        tick();                                   // edge 7 handshake
        check("t1_done_valid", 32'(rsp_valid), 32'd0);
        check("t1_done_busy",  32'(busy),      32'd0);

        // Back-pressure: the head is popped into service one edge after it
        // arrives, so five requests fit (one in service, four queued) and
        // the sixth waits for the first completion.
        rsp_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 1'b1; req_op = v_op[i]; req_addr = v_addr[i];
            check($sformatf("t2_ready_%0d", i), 32'(req_ready), 32'd1);
            tick();                               // edges a1..a5
        end
        check("t2_full", 32'(req_ready), 32'd0);
        req_op = v_op[5]; req_addr = v_addr[5];   // held while full
        tick();                                   // a6: first response
        check("t2_r0_valid", 32'(rsp_valid), 32'd1);
        check("t2_r0_op",    32'(rsp_op),    32'(v_op[0]));
        check("t2_r0_addr",  32'(rsp_addr),  32'(v_addr[0]));
        stable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_op !== v_op[0] ||
                rsp_addr !== v_addr[0] || req_ready !== 1'b0)
                stable = 1'b0;
        end
        check("t2_hold_stable", 32'(stable), 32'd1);
        check("t2_cnt_read",   cnt_read,   32'd2);
        check("t2_cnt_write",  cnt_write,  32'd1);
        check("t2_cnt_rfo",    cnt_rfo,    32'd1);
        check("t2_cnt_return", cnt_return, 32'd1);
        rsp_ready = 1'b1;
        tick();                                   // R: handshake
        check("t2_R_valid", 32'(rsp_valid), 32'd0);
        check("t2_R_ready", 32'(req_ready), 32'd0);
        tick();                                   // R+1: pop frees a slot
        check("t2_R1_ready", 32'(req_ready), 32'd1);
        tick();                                   // R+2: sixth accepted
        req_valid = 1'b0;
        check("t2_cnt_write6", cnt_write, 32'd2);
        tick(); tick();                           // R+3, R+4
        check("t2_gap", 32'(rsp_valid), 32'd0);
        tick();                                   // R+5
        check("t2_r1_valid", 32'(rsp_valid), 32'd1);
        check("t2_r1_op",    32'(rsp_op),    32'(v_op[1]));
        check("t2_r1_addr",  32'(rsp_addr),  32'(v_addr[1]));
        tick();
        for (int i = 2; i < 6; i++)
            expect_rsp($sformatf("t2_r%0d", i), v_op[i], v_addr[i]);
        drain("t2");

        // Mixed ops, then clear coinciding with an RFO accept
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1; req_op = 2'(i); req_addr = 26'(32'h40 + i);
            tick();
        end
        check("t3_read",   cnt_read,   32'd1);
        check("t3_write",  cnt_write,  32'd1);
        check("t3_rfo",    cnt_rfo,    32'd1);
        check("t3_return", cnt_return, 32'd1);
        req_op = OP_RFO; req_addr = 26'h50; clear = 1'b1;
        check("t3_ready_clr", 32'(req_ready), 32'd1);
        tick();
        clear = 1'b0; req_valid = 1'b0;
        check("t3_clr_read",   cnt_read,   32'd0);
        check("t3_clr_write",  cnt_write,  32'd0);
        check("t3_clr_rfo",    cnt_rfo,    32'd1);
        check("t3_clr_return", cnt_return, 32'd0);
        drain("t3");

        // Reset during WAIT with two requests queued
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1; req_op = OP_WRITE; req_addr = 26'(32'h77 + i);
            tick();
        end
        req_valid = 1'b0;
        check("t5_pre_busy",  32'(busy),      32'd1);
        check("t5_pre_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b1;
        tick();
        check("t5_valid", 32'(rsp_valid), 32'd0);
        check("t5_busy",  32'(busy),      32'd0);
        check("t5_ready", 32'(req_ready), 32'd0);
        check("t5_write", cnt_write,      32'd0);
        check("t5_rfo",   cnt_rfo,        32'd0);
        rst = 1'b0;
        saw_rsp = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) saw_rsp = 1'b1;
        end
        check("t5_no_stale", 32'(saw_rsp), 32'd0);

        // Saturation: preload the read counter just below all-ones
        force dut.r_cnt_read = 32'hFFFF_FFFE;
        tick();
        release dut.r_cnt_read;
        #1;
        check("t6_preload", cnt_read, 32'hFFFF_FFFE);
        req_valid = 1'b1; req_op = OP_READ; req_addr = 26'h0000123;
        tick();
        check("t6_first", cnt_read, 32'hFFFF_FFFF);
        tick();
        tick();
        req_valid = 1'b0;
        check("t6_sat",   cnt_read,  32'hFFFF_FFFF);
        check("t6_write", cnt_write, 32'd0);
        drain("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
